// File: rtl/bombe_pkg.sv
// Shared types and default sizing for the bombe search logic.
package bombe_pkg;

    localparam int unsigned ALPHABET              = 26;
    localparam int unsigned NUM_POSITIONS_DEFAULT = ALPHABET ** 3;
    localparam int unsigned POS_W_DEFAULT         = 15;
    localparam int unsigned CHECK_LATENCY_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        GOT1,
        GOT2,
        ARMED,
        SETTLE,
        TEST,
        FOUND,
        EXHAUSTED
    } state_e;

    // Datapath command strobes; at most one bit is set in any cycle.
    typedef struct packed {
        logic load_s1;
        logic load_s2;
        logic load_s3;
        logic rotor_clear;
        logic rotor_enable;
    } strobe_t;

    // Settle counter width able to hold the value lat (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/bombe_edge_detect.sv
// Rising-edge detector: one delay flop, combinational rise output.
module bombe_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic din_q;

    // Delay the input by one clock to compare against its current value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise_c = din & ~din_q;

endmodule

// File: rtl/bombe_search_controller.sv
// Sequencing FSM: captures three flag characters, then sweeps rotor settings.
module bombe_search_controller
    import bombe_pkg::*;
#(
    parameter int unsigned NUM_POSITIONS = NUM_POSITIONS_DEFAULT,
    parameter int unsigned POS_W         = POS_W_DEFAULT,
    parameter int unsigned CHECK_LATENCY = CHECK_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_press,
    input  logic             go,
    input  logic             match,
    output logic             load_s1,
    output logic             load_s2,
    output logic             load_s3,
    output logic             rotor_clear,
    output logic             rotor_enable,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [POS_W-1:0] position
);

    localparam int unsigned      CNT_W    = cnt_width(CHECK_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHECK_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POSITIONS - 1);

    state_e           state;
    state_e           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [POS_W-1:0] position_d;
    strobe_t          strobe;
    strobe_t          strobe_d;
    logic             busy_d;
    logic             found_d;
    logic             exhausted_d;
    logic             key_rise_c;

    bombe_edge_detect u_key_edge (
        .clk    (clk),
        .reset  (reset),
        .din    (key_press),
        .rise_c (key_rise_c)
    );

    // Next-state, counter, position and registered-output next values.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        position_d = position;
        strobe_d   = '0;

        case (state)
            IDLE: begin
                if (key_rise_c) begin
                    state_d          = GOT1;
                    strobe_d.load_s1 = 1'b1;
                end
            end
            GOT1: begin
                if (key_rise_c) begin
                    state_d          = GOT2;
                    strobe_d.load_s2 = 1'b1;
                end
            end
            GOT2: begin
                if (key_rise_c) begin
                    state_d          = ARMED;
                    strobe_d.load_s3 = 1'b1;
                end
            end
            ARMED: begin
                if (go) begin
                    state_d              = SETTLE;
                    strobe_d.rotor_clear = 1'b1;
                    position_d           = '0;
                    cnt_d                = CNT_LOAD;
                end
            end
            SETTLE: begin
                cnt_d = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_d = TEST;
                end
            end
            TEST: begin
                if (match) begin
                    state_d = FOUND;
                end else if (position == LAST_POS) begin
                    state_d = EXHAUSTED;
                end else begin
                    state_d               = SETTLE;
                    strobe_d.rotor_enable = 1'b1;
                    position_d            = position + POS_W'(1);
                    cnt_d                 = CNT_LOAD;
                end
            end
            FOUND, EXHAUSTED: begin
                if (key_rise_c) begin
                    state_d          = GOT1;
                    strobe_d.load_s1 = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == SETTLE) || (state_d == TEST);
        found_d     = (state_d == FOUND);
        exhausted_d = (state_d == EXHAUSTED);
    end

    // State, counter, position and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            position  <= '0;
            strobe    <= '0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            position  <= position_d;
            strobe    <= strobe_d;
            busy      <= busy_d;
            found     <= found_d;
            exhausted <= exhausted_d;
        end
    end

    assign load_s1      = strobe.load_s1;
    assign load_s2      = strobe.load_s2;
    assign load_s3      = strobe.load_s3;
    assign rotor_clear  = strobe.rotor_clear;
    assign rotor_enable = strobe.rotor_enable;

endmodule

// File: tb/tb_bombe_search_controller.sv
// Scoreboard bench for bombe_search_controller (small sweep, CHECK_LATENCY=2).
module tb_bombe_search_controller;

    localparam int N  = 8;
    localparam int CL = 2;
    localparam int PW = 4;
    localparam int P  = CL + 1;

    localparam int EV_L1    = 1;
    localparam int EV_L2    = 2;
    localparam int EV_L3    = 3;
    localparam int EV_CLR   = 4;
    localparam int EV_EN    = 5;
    localparam int EV_FOUND = 6;
    localparam int EV_EXH   = 7;

    typedef struct {
        int kind;
        int cyc;
        int pos;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          key_press = 1'b0;
    logic          go = 1'b0;
    logic          match;
    logic          load_s1, load_s2, load_s3, rotor_clear, rotor_enable;
    logic          busy, found, exhausted;
    logic [PW-1:0] position;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_en    = 0;
    int   target_pos = -1;
    bit   match_en = 1'b0;
    logic found_q = 1'b0;
    logic exh_q   = 1'b0;
    exp_t sb[$];

    bombe_search_controller #(
        .NUM_POSITIONS (N),
        .POS_W         (PW),
        .CHECK_LATENCY (CL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_press    (key_press),
        .go           (go),
        .match        (match),
        .load_s1      (load_s1),
        .load_s2      (load_s2),
        .load_s3      (load_s3),
        .rotor_clear  (rotor_clear),
        .rotor_enable (rotor_enable),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .position     (position)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: matches only at the chosen setting.
    assign match = match_en && (int'(position) == target_pos);

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int c, input int p);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.pos  = p;
        sb.push_back(e);
    endtask

    task automatic note(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", kind, 0);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (e.pos >= 0) check("event_pos", int'(position), e.pos);
        end
    endtask

    // Output monitor: every strobe and status rise is matched against the scoreboard.
    always @(negedge clk) begin
        if ({load_s1, load_s2, load_s3, rotor_clear, rotor_enable} != 5'b0) begin
            check("strobe_onehot",
                  $countones({load_s1, load_s2, load_s3, rotor_clear, rotor_enable}), 1);
            if (load_s1)      note(EV_L1);
            if (load_s2)      note(EV_L2);
            if (load_s3)      note(EV_L3);
            if (rotor_clear)  note(EV_CLR);
            if (rotor_enable) note(EV_EN);
        end
        if (rotor_enable) n_en <= n_en + 1;
        if (found && !found_q)    note(EV_FOUND);
        if (exhausted && !exh_q)  note(EV_EXH);
        found_q <= found;
        exh_q   <= exhausted;
    end

    task automatic press(input int kind, input bit expect_load);
        @(negedge clk);
        key_press = 1'b1;
        if (expect_load) push_exp(kind, cyc + 1, -1);
        repeat (5) @(negedge clk);
        key_press = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_flags();
        press(EV_L1, 1'b1);
        press(EV_L2, 1'b1);
        press(EV_L3, 1'b1);
    endtask

    // Pulse go and predict the whole sweep; final_kind 0 means no end event expected.
    task automatic start(input int last, input int final_kind, output int t_go);
        @(negedge clk);
        go   = 1'b1;
        t_go = cyc + 1;
        push_exp(EV_CLR, t_go, 0);
        for (int k = 1; k <= last; k++) push_exp(EV_EN, t_go + P * k, k);
        if (final_kind != 0) push_exp(final_kind, t_go + P * (last + 1), last);
        @(negedge clk);
        go = 1'b0;
        check("busy_after_go", int'(busy), 1);
        check("pos_after_go", int'(position), 0);
    endtask

    task automatic wait_done(input int t_go, output int dt);
        dt = -1;
        for (int i = 0; i < 400 && dt < 0; i++) begin
            @(negedge clk);
            if (found || exhausted) dt = cyc - t_go;
        end
        if (dt < 0) check("done_timeout", 0, 1);
    endtask

    function automatic int all_outputs();
        return int'({load_s1, load_s2, load_s3, rotor_clear, rotor_enable,
                     busy, found, exhausted});
    endfunction

    initial begin
        int t_go;
        int dt;
        int en0;
        bit seen;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        check("reset_pos", int'(position), 0);
        reset = 1'b1;

        // Job 1: early go ignored in GOT1, hit at setting 5
        match_en   = 1'b1;
        target_pos = 5;
        press(EV_L1, 1'b1);
        @(negedge clk);
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        check("early_go_no_busy", int'(busy), 0);
        press(EV_L2, 1'b1);
        press(EV_L3, 1'b1);
        en0 = n_en;
        start(5, EV_FOUND, t_go);
        wait_done(t_go, dt);
        @(negedge clk);
        check("hit5_time", dt, P * 6);
        check("hit5_found", int'(found), 1);
        check("hit5_exhausted", int'(exhausted), 0);
        check("hit5_pos", int'(position), 5);
        check("hit5_busy", int'(busy), 0);
        check("hit5_enables", n_en - en0, 5);

        // Job 2: no hit, key ignored while ARMED
        match_en = 1'b0;
        press(EV_L1, 1'b1);
        check("found_cleared", int'(found), 0);
        press(EV_L2, 1'b1);
        press(EV_L3, 1'b1);
        press(EV_L1, 1'b0);
        en0 = n_en;
        start(N - 1, EV_EXH, t_go);
        wait_done(t_go, dt);
        @(negedge clk);
        check("nohit_time", dt, 24);
        check("nohit_exhausted", int'(exhausted), 1);
        check("nohit_found", int'(found), 0);
        check("nohit_pos", int'(position), N - 1);
        check("nohit_enables", n_en - en0, N - 1);

        // Job 3: match at the last setting reports FOUND
        match_en   = 1'b1;
        target_pos = N - 1;
        load_flags();
        en0 = n_en;
        start(N - 1, EV_FOUND, t_go);
        wait_done(t_go, dt);
        repeat (6) @(negedge clk);
        check("last_time", dt, P * N);
        check("last_found", int'(found), 1);
        check("last_exhausted", int'(exhausted), 0);
        check("last_pos", int'(position), N - 1);
        check("last_enables", n_en - en0, N - 1);

        // Job 4: reset while the sweep sits at setting 3
        match_en = 1'b0;
        load_flags();
        start(3, 0, t_go);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (int'(position) == 3) seen = 1'b1;
        end
        check("reach_pos3", int'(seen), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_outputs", all_outputs(), 0);
        check("midreset_pos", int'(position), 0);
        check("midreset_sb_empty", sb.size(), 0);
        repeat (6) @(negedge clk);
        check("midreset_idle_outputs", all_outputs(), 0);

        // After reset a new job starts normally and hits at setting 2
        match_en   = 1'b1;
        target_pos = 2;
        load_flags();
        start(2, EV_FOUND, t_go);
        wait_done(t_go, dt);
        @(negedge clk);
        check("post_reset_time", dt, P * 3);
        check("post_reset_pos", int'(position), 2);
        check("post_reset_found", int'(found), 1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
